mux4_sel_reg: RTL and testbench

- Registered 4:1 selector for a WIDTH-bit datapath.
- Two select bits {s1,s0} pick one of inputs a, b, c, d.
- The choice is captured into an output register on each enabled clock.
- Used as a generic steering element in control/datapath glue where a clean, glitch-free registered output is needed.

---
 rtl/mux4_sel_reg_if.sv | 41 ++++
 rtl/mux4_sel_reg.sv | 140 ++++++++++++++
 tb/tb_mux4_sel_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mux4_sel_reg_if.sv
// mux4_sel_reg_if: data/select bundle for the registered 4:1 selector.
// Stats signals exist only when MUX4_SEL_STATS_EN is defined.
interface mux4_sel_reg_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [1:0]       sel_q;
`ifdef MUX4_SEL_STATS_EN
  logic             stats_clr;
  logic [15:0]      cnt_a;
  logic [15:0]      cnt_b;
  logic [15:0]      cnt_c;
  logic [15:0]      cnt_d;
`endif

  modport master (
    output en, a, b, c, d, s0, s1,
`ifdef MUX4_SEL_STATS_EN
    output stats_clr,
    input  cnt_a, cnt_b, cnt_c, cnt_d,
`endif
    input  y, y_valid, sel_q
  );

  modport slave (
    input  en, a, b, c, d, s0, s1,
`ifdef MUX4_SEL_STATS_EN
    input  stats_clr,
    output cnt_a, cnt_b, cnt_c, cnt_d,
`endif
    output y, y_valid, sel_q
  );
endinterface

// File: rtl/mux4_sel_reg.sv
// mux4_sel_reg: registered 4:1 selector, {s1,s0} picks a/b/c/d.
// MUX4_SEL_STATS_EN adds saturating per-input capture counters.
module mux4_sel_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  mux4_sel_reg_if.slave bus
);

  logic [1:0]       sel_idx;
  logic [WIDTH-1:0] mux_out;

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       sel_d;
  logic [1:0]       sel_q;
  logic             vld_d;
  logic             vld_q;

  assign sel_idx = {bus.s1, bus.s0};

  // Internal select; default maps to d so no latch is inferred.
  always_comb begin
    mux_out = bus.d;
    case (sel_idx)
      2'b00:   mux_out = bus.a;
      2'b01:   mux_out = bus.b;
      2'b10:   mux_out = bus.c;
      default: mux_out = bus.d;
    endcase
  end

  // Capture on en, otherwise hold data and drop valid.
  always_comb begin
    y_d   = y_q;
    sel_d = sel_q;
    vld_d = 1'b0;
    if (bus.en) begin
      y_d   = mux_out;
      sel_d = sel_idx;
      vld_d = 1'b1;
    end
  end

  // Output register; synchronous reset wins over capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= RST_VAL;
      sel_q <= 2'b00;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel_q   = sel_q;
  assign bus.y_valid = vld_q;

`ifdef MUX4_SEL_STATS_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [15:0] cnt_a_d;
  logic [15:0] cnt_a_q;
  logic [15:0] cnt_b_d;
  logic [15:0] cnt_b_q;
  logic [15:0] cnt_c_d;
  logic [15:0] cnt_c_q;
  logic [15:0] cnt_d_d;
  logic [15:0] cnt_d_q;
  logic        hit_a;
  logic        hit_b;
  logic        hit_c;
  logic        hit_d;

  // One-hot capture hit per input.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    hit_c = 1'b0;
    hit_d = 1'b0;
    if (bus.en) begin
      case (sel_idx)
        2'b00:   hit_a = 1'b1;
        2'b01:   hit_b = 1'b1;
        2'b10:   hit_c = 1'b1;
        default: hit_d = 1'b1;
      endcase
    end
  end

  // Clear beats increment; counters stick at max.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    cnt_d_d = cnt_d_q;
    if (bus.stats_clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_c_d = '0;
      cnt_d_d = '0;
    end else begin
      if (hit_a && cnt_a_q != CNT_MAX)
        cnt_a_d = cnt_a_q + 16'd1;
      if (hit_b && cnt_b_q != CNT_MAX)
        cnt_b_d = cnt_b_q + 16'd1;
      if (hit_c && cnt_c_q != CNT_MAX)
        cnt_c_d = cnt_c_q + 16'd1;
      if (hit_d && cnt_d_q != CNT_MAX)
        cnt_d_d = cnt_d_q + 16'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      cnt_d_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
  assign bus.cnt_c = cnt_c_q;
  assign bus.cnt_d = cnt_d_q;
`endif

endmodule

// File: tb/tb_mux4_sel_reg.sv
// tb_mux4_sel_reg: scoreboard bench for mux4_sel_reg (WIDTH=8).
// Stimulus pushes expected state; monitor pops after each edge.
module tb_mux4_sel_reg;

  localparam int         W    = 8;
  localparam logic [7:0] RSTV = 8'hA5;

  typedef struct {
    logic [7:0]  y;
    logic        v;
    logic [1:0]  sel;
    logic [15:0] cnt [4];
  } exp_t;

  logic clk;
  logic rst_n;

  mux4_sel_reg_if #(.WIDTH(W)) bus ();

  mux4_sel_reg #(
    .WIDTH  (W),
    .RST_VAL(RSTV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb [$];
  int   n_chk;
  int   n_fail;

  logic [7:0] m_y;
  logic       m_v;
  logic [1:0] m_sel;
  int         m_cnt [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [1:0] s,
                      input logic [7:0] va, input logic [7:0] vb,
                      input logic [7:0] vc, input logic [7:0] vd,
                      input logic clr);
    logic [7:0] data [4];
    exp_t       x;
    @(negedge clk);
    rst_n  = r;
    bus.en = e;
    bus.a  = va;
    bus.b  = vb;
    bus.c  = vc;
    bus.d  = vd;
    bus.s0 = s[0];
    bus.s1 = s[1];
`ifdef MUX4_SEL_STATS_EN
    bus.stats_clr = clr;
`endif
    data[0] = va;
    data[1] = vb;
    data[2] = vc;
    data[3] = vd;
    if (!r) begin
      m_y   = RSTV;
      m_v   = 1'b0;
      m_sel = 2'd0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (e && m_cnt[s] < 65535) begin
        m_cnt[s] = m_cnt[s] + 1;
      end
      m_v = e;
      if (e) begin
        m_y   = data[s];
        m_sel = s;
      end
    end
    x.y   = m_y;
    x.v   = m_v;
    x.sel = m_sel;
    for (int i = 0; i < 4; i++) x.cnt[i] = 16'(m_cnt[i]);
    sb.push_back(x);
  endtask

  // Monitor: compare DUT state shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("y", 16'(bus.y), 16'(e.y));
        chk("y_valid", 16'(bus.y_valid), 16'(e.v));
        chk("sel_q", 16'(bus.sel_q), 16'(e.sel));
`ifdef MUX4_SEL_STATS_EN
        chk("cnt_a", bus.cnt_a, e.cnt[0]);
        chk("cnt_b", bus.cnt_b, e.cnt[1]);
        chk("cnt_c", bus.cnt_c, e.cnt[2]);
        chk("cnt_d", bus.cnt_d, e.cnt[3]);
`endif
      end
    end
  end

  initial begin
    logic [1:0] pat [4];
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    bus.c  = '0;
    bus.d  = '0;
    bus.s0 = 1'b0;
    bus.s1 = 1'b0;
`ifdef MUX4_SEL_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    m_y   = 'x;
    m_v   = 1'bx;
    m_sel = 'x;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;

    // reset two cycles, then idle with en=0
    step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'hFF, 0);
    repeat (3)
      step(1, 0, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 0);

    // only d=1; selects 00,10,01,11 held 2 cycles each
    pat[0] = 2'd0;
    pat[1] = 2'd2;
    pat[2] = 2'd1;
    pat[3] = 2'd3;
    for (int i = 0; i < 4; i++)
      repeat (2)
        step(1, 1, pat[i], 8'h00, 8'h00, 8'h00, 8'h01, 0);

    // cycle through all selects with distinct data
    for (int i = 0; i < 8; i++)
      step(1, 1, 2'(i), 8'h11, 8'h22, 8'h33, 8'h44, 0);

    // capture d then hold with en=0 while select moves
    step(1, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h01, 0);
    repeat (3)
      step(1, 0, 2'd0, 8'hAA, 8'h00, 8'h00, 8'h01, 0);

    // reset mid-stream, then resume
    step(1, 1, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    step(0, 1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    step(1, 1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    step(1, 1, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 0);

    // counters: reset, 3x d, 1x a, then clear (clear beats capture)
    step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    repeat (3)
      step(1, 1, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    step(1, 1, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    step(1, 0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    step(1, 1, 2'd2, 8'h01, 8'h02, 8'h03, 8'h04, 1);
    step(1, 1, 2'd1, 8'h01, 8'h02, 8'h03, 8'h04, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 29) != 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom),
           ($urandom_range(0, 19) == 0));

    repeat (3) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
